mod_n_event_detector: RTL

Parametrised successor to the lab's single-input ones-counting FSM. It counts qualifying events on a serial input `ain` and flags every MOD-th event as the completion of a group. It adds configurable group length, counter width, level or rising-edge event mode, saturating or wrapping count, overflow detection, synchronous clear and an optionally registered output. It sits between a debounced switch/serial input and the display/LED logic on the FPGA lab board.

---
 rtl/mod_det_pkg.sv | 21 ++
 rtl/ain_event_gen.sv | 38 +++
 rtl/mod_n_event_detector.sv | 118 +++++++++++
 3 files changed

// File: rtl/mod_det_pkg.sv
// Shared types and mode constants for the mod-N event detector.
// The detector top and its event-generator sub-module both import this package.
package mod_det_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int MODE_LEVEL = 32'sd0;
   localparam int MODE_EDGE  = 32'sd1;
   localparam int SAT_WRAP   = 32'sd0;
   localparam int SAT_HOLD   = 32'sd1;

   // Group completion happens when the phase reaches its last slot.
   // Using >= also recovers from an out-of-range phase value.
   function automatic logic phase_is_last(input int unsigned ph, input int unsigned last_ph);
      return (ph >= last_ph);
   endfunction

endpackage

// File: rtl/ain_event_gen.sv
// Samples the serial input and qualifies events in either level or rising-edge mode.
// Events are gated by reset so that a combinational strobe downstream stays low while reset is held.
module ain_event_gen
   import mod_det_pkg::*;
#(
   parameter int EDGE_MODE = MODE_LEVEL
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic ain,
   output logic ev
);

   logic ain_q_r;
   logic raw_s;

   // Previous-cycle copy of ain; it keeps sampling during clear and while en is low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ain_q_r <= 1'b0;
      end else begin
         ain_q_r <= ain;
      end
   end

   // Raw event, then qualified by en and masked by reset.
   always_comb begin
      raw_s = 1'b0;
      if (EDGE_MODE == MODE_EDGE) begin
         raw_s = ain & ~ain_q_r;
      end else begin
         raw_s = ain;
      end
      ev = raw_s & en & reset;
   end

endmodule

// File: rtl/mod_n_event_detector.sv
// Counts qualified events on ain and strobes yout on every MOD-th event of a group.
// Holds the two-state FSM, phase and event counters, sticky overflow and the output stage.
module mod_n_event_detector
   import mod_det_pkg::*;
#(
   parameter  int MOD       = 32'sd3,
   parameter  int CNT_W     = 32'sd4,
   parameter  int EDGE_MODE = MODE_LEVEL,
   parameter  int SAT       = SAT_WRAP,
   parameter  int REG_OUT   = 32'sd0,
   localparam int PH_W      = $clog2(MOD)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic             ain,
   output logic             yout,
   output logic [CNT_W-1:0] count,
   output logic             ovf,
   output logic [PH_W-1:0]  phase,
   output logic             busy
);

   localparam logic [PH_W-1:0]  PH_LAST = PH_W'(MOD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_r, state_s;
   logic [PH_W-1:0]  phase_r, phase_s;
   logic [CNT_W-1:0] count_r, count_s;
   logic             ovf_r, ovf_s;
   logic             done_s;
   logic             yreg_r;
   logic             ev_s;

   ain_event_gen #(
      .EDGE_MODE(EDGE_MODE)
   ) u_ain_event_gen (
      .clk  (clk),
      .reset(reset),
      .en   (en),
      .ain  (ain),
      .ev   (ev_s)
   );

   // Next-state, phase, count and overflow; clear beats any event in the same cycle.
   always_comb begin
      state_s = state_r;
      phase_s = phase_r;
      count_s = count_r;
      ovf_s   = ovf_r;
      done_s  = 1'b0;
      if (clr) begin
         state_s = ST_IDLE;
         phase_s = '0;
         count_s = '0;
         ovf_s   = 1'b0;
      end else if (ev_s) begin
         case (state_r)
            ST_IDLE: begin
               state_s = ST_RUN;
               phase_s = PH_W'(1'b1);
            end
            ST_RUN: begin
               if (phase_is_last(32'(phase_r), 32'(PH_LAST))) begin
                  phase_s = '0;
                  done_s  = 1'b1;
               end else begin
                  phase_s = phase_r + PH_W'(1'b1);
               end
            end
            default: begin
               state_s = ST_IDLE;
               phase_s = '0;
            end
         endcase
         if (count_r == CNT_MAX) begin
            ovf_s   = 1'b1;
            count_s = (SAT == SAT_HOLD) ? CNT_MAX : '0;
         end else begin
            count_s = count_r + CNT_W'(1'b1);
         end
      end else begin
         state_s = state_r;
      end
   end

   // State registers, including the delayed completion strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         phase_r <= '0;
         count_r <= '0;
         ovf_r   <= 1'b0;
         yreg_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         phase_r <= phase_s;
         count_r <= count_s;
         ovf_r   <= ovf_s;
         yreg_r  <= done_s;
      end
   end

   // Output stage: Mealy strobe or its registered copy.
   always_comb begin
      if (REG_OUT != 0) begin
         yout = yreg_r;
      end else begin
         yout = done_s;
      end
      count = count_r;
      ovf   = ovf_r;
      phase = phase_r;
      busy  = (state_r == ST_RUN);
   end

endmodule
